// File: rtl/i2s_rx_frontend.sv
// rtl/i2s_rx_frontend.sv - I2S receiver: pin sync, frame lock, 16-bit stereo pair output
module i2s_rx_frontend #(
    parameter int SLOT_BITS = 32,
    parameter int DATA_BITS = 24,
    parameter int OUT_BITS  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                I2S_sclk,
    input  logic                I2S_ws,
    input  logic                I2S_data,
    output logic [OUT_BITS-1:0] lft_chnnl,
    output logic [OUT_BITS-1:0] rght_chnnl,
    output logic                vld,
    output logic                locked,
    output logic                sync_err
);

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} rxState;

    localparam logic [5:0] SLOT_LAST = 6'(SLOT_BITS - 1);
    localparam logic [5:0] DATA_LAST = 6'(DATA_BITS);
    localparam logic [5:0] CNT_SAT   = 6'd63;

    logic sclkS1, sclkS2, sclkS3;
    logic wsS1, wsS2;
    logic dataS1, dataS2;
    logic rise, trans;

    logic                 wsPrev;
    logic [5:0]           bitCnt, cntNext;
    logic [DATA_BITS-1:0] shiftReg, holdReg;
    rxState               state, stateNext;

    logic errNext, latchHold, lsbDone, capBit, pairPend;

    assign rise  = sclkS2 & ~sclkS3;
    assign trans = wsS2 != wsPrev;

    // Transition rise carries the previous word's trailing bit, so it restarts the count without capturing.
    always_comb begin
        cntNext = bitCnt;
        if (trans)
            cntNext = 6'd0;
        else if (bitCnt != CNT_SAT)
            cntNext = bitCnt + 6'd1;
    end

    assign capBit = rise && !trans && (state != SYNC)
                    && (cntNext >= 6'd1) && (cntNext <= DATA_LAST);

    always_comb begin
        stateNext = state;
        errNext   = 1'b0;
        latchHold = 1'b0;
        lsbDone   = 1'b0;
        if (rise) begin
            case (state)
                SYNC: begin
                    if (trans && !wsS2)
                        stateNext = LEFT;
                end
                LEFT: begin
                    if (trans) begin
                        if (wsS2 && bitCnt == SLOT_LAST) begin
                            stateNext = RIGHT;
                            latchHold = 1'b1;
                        end else begin
                            errNext   = 1'b1;
                            stateNext = SYNC;
                        end
                    end else if (bitCnt == CNT_SAT) begin
                        errNext   = 1'b1;
                        stateNext = SYNC;
                    end
                end
                RIGHT: begin
                    if (trans) begin
                        if (!wsS2 && bitCnt == SLOT_LAST) begin
                            stateNext = LEFT;
                        end else begin
                            errNext   = 1'b1;
                            stateNext = SYNC;
                        end
                    end else if (bitCnt == CNT_SAT) begin
                        errNext   = 1'b1;
                        stateNext = SYNC;
                    end else if (cntNext == DATA_LAST) begin
                        lsbDone = 1'b1;
                    end
                end
                default: stateNext = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclkS1     <= 1'b0;
            sclkS2     <= 1'b0;
            sclkS3     <= 1'b0;
            wsS1       <= 1'b0;
            wsS2       <= 1'b0;
            dataS1     <= 1'b0;
            dataS2     <= 1'b0;
            wsPrev     <= 1'b0;
            bitCnt     <= 6'd0;
            shiftReg   <= '0;
            holdReg    <= '0;
            state      <= SYNC;
            pairPend   <= 1'b0;
            lft_chnnl  <= '0;
            rght_chnnl <= '0;
            vld        <= 1'b0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            sclkS1 <= I2S_sclk;
            sclkS2 <= sclkS1;
            sclkS3 <= sclkS2;
            wsS1   <= I2S_ws;
            wsS2   <= wsS1;
            dataS1 <= I2S_data;
            dataS2 <= dataS1;

            state    <= stateNext;
            locked   <= stateNext != SYNC;
            sync_err <= errNext;
            pairPend <= lsbDone;
            vld      <= pairPend;

            if (rise) begin
                wsPrev <= wsS2;
                bitCnt <= cntNext;
            end
            if (capBit)
                shiftReg <= {shiftReg[DATA_BITS-2:0], dataS2};
            if (latchHold)
                holdReg <= shiftReg;
            // Right LSB landed in shiftReg on the previous edge; publish both halves together.
            if (pairPend) begin
                lft_chnnl  <= holdReg[DATA_BITS-1 -: OUT_BITS];
                rght_chnnl <= shiftReg[DATA_BITS-1 -: OUT_BITS];
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_frontend.sv
// tb/tb_i2s_rx_frontend.sv - scoreboard bench for i2s_rx_frontend
module tb_i2s_rx_frontend;

    localparam int HALF_SCLK = 160;
    localparam int FRAME_NS  = 64 * 2 * HALF_SCLK;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0, ws = 1'b0, sdata = 1'b0;
    logic [15:0] lft, rght;
    logic vld, locked, syncErr;

    int total = 0;
    int bad = 0;
    int vldCount = 0;
    int errCount = 0;
    logic [31:0] expQ[$];
    time vldTimes[$];
    time lsbRise = 0;
    logic [31:0] monExp;
    time monLat;

    always #5 clk = ~clk;

    i2s_rx_frontend dut (
        .clk(clk),
        .rst(rst),
        .I2S_sclk(sclk),
        .I2S_ws(ws),
        .I2S_data(sdata),
        .lft_chnnl(lft),
        .rght_chnnl(rght),
        .vld(vld),
        .locked(locked),
        .sync_err(syncErr)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic sendSlot(input logic ch, input logic [23:0] word, input int nPer);
        for (int p = 0; p < nPer; p++) begin
            ws = ch;
            sdata = (p >= 1 && p <= 24) ? word[24-p] : (p == 0);
            #HALF_SCLK;
            sclk = 1'b1;
            if (ch && p == 24) lsbRise = $time;
            #HALF_SCLK;
            sclk = 1'b0;
        end
    endtask

    task automatic sendFrame(input logic [23:0] l, input logic [23:0] r, input logic [31:0] expPair);
        expQ.push_back(expPair);
        sendSlot(1'b0, l, 32);
        sendSlot(1'b1, r, 32);
    endtask

    always @(negedge clk) begin
        if (syncErr) errCount++;
        if (vld) begin
            vldCount++;
            vldTimes.push_back($time);
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_vld got=%h exp=none", {lft, rght});
            end else begin
                monExp = expQ.pop_front();
                check("pair", {lft, rght}, monExp);
                monLat = $time - lsbRise;
                total++;
                if (monLat < 30 || monLat > 50) begin
                    bad++;
                    $display("FAIL latency got=%0t exp=30..50", monLat);
                end
            end
        end
    end

    logic [23:0] lTab[8] = '{24'h123456, 24'hFFFFFF, 24'h000000, 24'h8000FF,
                             24'hA5A5A5, 24'h0001FF, 24'hC3C3C3, 24'h000100};
    logic [23:0] rTab[8] = '{24'hABCDEF, 24'h000000, 24'hFFFFFF, 24'h7FFF00,
                             24'h5A5A5A, 24'hFFFE00, 24'h3C3C3C, 24'h8000FF};
    logic [31:0] eTab[8] = '{32'h1234ABCD, 32'hFFFF0000, 32'h0000FFFF, 32'h80007FFF,
                             32'hA5A55A5A, 32'h0001FFFE, 32'hC3C33C3C, 32'h00018000};

    initial begin
        int e0, v0;
        time d;

        rst = 1'b1;
        ws = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {lft, rght, vld, locked, syncErr}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        sendSlot(1'b1, 24'h000000, 32);
        check("locked_before_lock", locked, 0);
        sendFrame(24'h7FFF00, 24'h800100, 32'h7FFF8001);
        check("locked_first", locked, 1);
        check("first_lft", lft, 16'h7FFF);
        check("first_rght", rght, 16'h8001);
        check("first_vld_count", vldCount, 1);

        vldTimes.delete();
        for (int i = 0; i < 8; i++) sendFrame(lTab[i], rTab[i], eTab[i]);
        check("burst_vld_count", vldCount, 9);
        check("burst_ts_count", vldTimes.size(), 8);
        for (int i = 1; i < vldTimes.size(); i++) begin
            d = vldTimes[i] - vldTimes[i-1];
            total++;
            if (d < FRAME_NS - 10 || d > FRAME_NS + 10) begin
                bad++;
                $display("FAIL spacing got=%0t exp=%0d", d, FRAME_NS);
            end
        end
        check("burst_no_err", errCount, 0);

        e0 = errCount;
        v0 = vldCount;
        sendSlot(1'b0, 24'h111111, 20);
        sendSlot(1'b1, 24'h222222, 32);
        check("short_err", errCount - e0, 1);
        check("short_locked", locked, 0);
        check("short_no_vld", vldCount, v0);
        sendFrame(24'h4321AB, 24'hFEDC98, 32'h4321FEDC);
        check("short_relock", locked, 1);
        check("short_recover_vld", vldCount, v0 + 1);

        @(negedge clk);
        rst = 1'b1;
        ws = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        v0 = vldCount;
        sendSlot(1'b0, 24'h999999, 12);
        sendSlot(1'b1, 24'h777777, 32);
        check("midleft_no_vld", vldCount, v0);
        check("midleft_unlocked", locked, 0);
        sendFrame(24'h0ACE00, 24'hF13500, 32'h0ACEF135);
        check("midleft_vld", vldCount, v0 + 1);
        check("midleft_locked", locked, 1);

        v0 = vldCount;
        sendSlot(1'b0, 24'h5555AA, 32);
        sendSlot(1'b1, 24'h33CC00, 10);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", {lft, rght, vld, locked, syncErr}, 64'd0);
        #16;
        rst = 1'b0;
        sendSlot(1'b1, 24'h33CC00, 22);
        check("rst_frame_dropped", vldCount, v0);
        sendFrame(24'h654321, 24'h123456, 32'h65431234);
        check("rst_recover_vld", vldCount, v0 + 1);

        e0 = errCount;
        v0 = vldCount;
        expQ.push_back(32'h13572468);
        sendSlot(1'b0, 24'h135799, 32);
        sendSlot(1'b1, 24'h246800, 70);
        check("stuck_err", errCount - e0, 1);
        check("stuck_unlocked", locked, 0);
        check("stuck_vld", vldCount, v0 + 1);
        sendFrame(24'hBEEF12, 24'hCAFE34, 32'hBEEFCAFE);
        check("stuck_relock", locked, 1);
        check("stuck_recover_vld", vldCount, v0 + 2);
        check("stuck_no_extra_err", errCount - e0, 1);

        repeat (10) @(posedge clk);
        #1;
        check("queue_drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
